// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core's memory port: access sizes,
// MMIO register offsets and console status bit positions.
package riscv_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } memsize_e;

    localparam logic [3:0] CONSOLE  = 4'h0;
    localparam logic [3:0] CYCLE_LO = 4'h4;
    localparam logic [3:0] CYCLE_HI = 4'h8;
    localparam logic [3:0] EXIT     = 4'hC;

    localparam int CON_FULL_BIT  = 0;
    localparam int CON_EMPTY_BIT = 1;
    localparam int CON_OVF_BIT   = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop and full/empty flags. A pop frees a slot
// on the same edge, so push-while-full is accepted when it coincides with a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; reads are only meaningful while non-empty.
    always_ff @(posedge clk) begin
        if (do_push && !reset) store[wr_ptr] <= din;
    end

endmodule

// File: rtl/data_mem.sv
// Data-memory responder: word RAM with sized loads/stores plus an optional
// MMIO window (console FIFO, cycle counter, exit) enabled by DATA_MEM_MMIO_EN.
module data_mem
    import riscv_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int          TX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [2:0]  memsize,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        exit_valid,
    output logic [31:0] exit_code,
    output logic        misalign
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] idx;
    logic [31:0]   rword;
    logic          is_byte;
    logic          is_half;
    logic          mis;
    logic          hit;
    logic [31:0]   mmio_rd;
    logic [3:0]    be;
    logic [31:0]   wlanes;

    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [2:0]  size,
                                             input logic [1:0]  off);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = 8'(w >> {off, 3'b000});
        h = 16'(w >> {off[1], 4'b0000});
        case (size)
            MEM_B:   r = b;
            MEM_H:   r = h;
            MEM_BU:  r = {24'd0, b};
            MEM_HU:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign idx     = addr[AW+1:2];
    assign rword   = mem[idx];
    assign is_byte = (memsize[1:0] == 2'b00);
    assign is_half = (memsize[1:0] == 2'b01);
    // Undefined size codes behave as word accesses for alignment and reads.
    assign mis     = (is_half && addr[0]) ||
                     (!is_byte && !is_half && (addr[1:0] != 2'b00));

    always_comb begin
        be     = 4'b0000;
        wlanes = writedata;
        if (memwrite && !reset && !hit && !mis) begin
            case (memsize)
                MEM_B, MEM_BU: begin
                    be     = 4'b0001 << addr[1:0];
                    wlanes = {4{writedata[7:0]}};
                end
                MEM_H, MEM_HU: begin
                    be     = addr[1] ? 4'b1100 : 4'b0011;
                    wlanes = {2{writedata[15:0]}};
                end
                MEM_W:   be = 4'b1111;
                default: be = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
        end
    end

    always_comb begin
        if (hit)      readdata = mmio_rd;
        else if (mis) readdata = 32'd0;
        else          readdata = load_ext(rword, memsize, addr[1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset)            misalign <= 1'b0;
        else if (!hit && mis) misalign <= 1'b1;
    end

`ifdef DATA_MEM_MMIO_EN
    logic [63:0] cycle;
    logic        overflow;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic [7:0]  head;
    logic [31:0] status;

    assign hit      = (addr[31:4] == MMIO_BASE[31:4]);
    assign push     = memwrite && hit && (addr[3:2] == CONSOLE[3:2]);
    assign pop      = tx_valid && tx_ready;
    assign tx_valid = !fifo_empty;
    assign tx_data  = tx_valid ? head : 8'd0;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (writedata[7:0]),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle      <= 64'd0;
            overflow   <= 1'b0;
            exit_valid <= 1'b0;
            exit_code  <= 32'd0;
        end else begin
            cycle <= cycle + 64'd1;
            if (push && fifo_full && !pop) overflow <= 1'b1;
            if (memwrite && hit && (addr[3:2] == EXIT[3:2]) && !exit_valid) begin
                exit_valid <= 1'b1;
                exit_code  <= writedata;
            end
        end
    end

    always_comb begin
        status                = 32'd0;
        status[CON_FULL_BIT]  = fifo_full;
        status[CON_EMPTY_BIT] = fifo_empty;
        status[CON_OVF_BIT]   = overflow;
        case (addr[3:2])
            CONSOLE[3:2]:  mmio_rd = status;
            CYCLE_LO[3:2]: mmio_rd = cycle[31:0];
            CYCLE_HI[3:2]: mmio_rd = cycle[63:32];
            default:       mmio_rd = exit_code;
        endcase
    end
`else
    logic unused_ok;

    assign hit        = 1'b0;
    assign mmio_rd    = 32'd0;
    assign tx_valid   = 1'b0;
    assign tx_data    = 8'd0;
    assign exit_valid = 1'b0;
    assign exit_code  = 32'd0;
    assign unused_ok  = &{1'b0, tx_ready, addr[31:AW+2]};
`endif

endmodule
